// File: rtl/mixer_pkg.sv
// Shared mode encodings and sequencer state constants for the mixer control path.
package mixer_pkg;

  localparam logic [1:0] MODE_EDIT = 2'd0;
  localparam logic [1:0] MODE_PLAY = 2'd1;
  localparam logic [1:0] MODE_RAW  = 2'd2;

  typedef enum logic [1:0] {
    Edit = MODE_EDIT,
    Play = MODE_PLAY,
    Raw  = MODE_RAW
  } sysmode_t;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_STABLE   = 2'd0;
  localparam seq_state_t ST_FADE_OUT = 2'd1;
  localparam seq_state_t ST_SWAP     = 2'd2;
  localparam seq_state_t ST_FADE_IN  = 2'd3;

  // Resolves simultaneous requests: edit beats play beats raw.
  function automatic sysmode_t req_target(input logic set_edit, input logic set_play,
                                          input logic set_raw);
    if (set_edit) begin
      return Edit;
    end else if (set_play) begin
      return Play;
    end else if (set_raw) begin
      return Raw;
    end
    return Edit;
  endfunction

endpackage

// File: rtl/gain_ramp.sv
// Saturating up/down master gain register; resets to full scale.
module gain_ramp #(
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned GAIN_STEP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up,
  input  logic              down,
  input  logic              load_max,
  input  logic              load_zero,
  output logic [GAIN_W-1:0] gain
);

  localparam logic [GAIN_W:0] StepW = (GAIN_W+1)'(GAIN_STEP);
  localparam logic [GAIN_W:0] MaxW  = {1'b0, {GAIN_W{1'b1}}};

  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [GAIN_W:0]   wide;

  // One extra bit of headroom so the saturation compares never wrap.
  always_comb begin
    gain_d = gain_q;
    wide   = {1'b0, gain_q};
    if (load_max) begin
      gain_d = '1;
    end else if (load_zero) begin
      gain_d = '0;
    end else if (down) begin
      gain_d = (wide <= StepW) ? '0 : GAIN_W'(wide - StepW);
    end else if (up) begin
      gain_d = ((wide + StepW) >= MaxW) ? '1 : GAIN_W'(wide + StepW);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gain_q <= '1;
    end else begin
      gain_q <= gain_d;
    end
  end

  assign gain = gain_q;

endmodule

// File: rtl/mode_sequencer.sv
// Mixer mode sequencer with per-channel mute/select editing.
// Define MODE_SEQ_FADE_EN to fade gain out/in around each mode change.
module mode_sequencer
  import mixer_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned GAIN_STEP = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_edit,
  input  logic                      set_play,
  input  logic                      set_raw,
  input  logic                      ch_next,
  input  logic                      ch_mute_tgl,
  output logic [1:0]                mode,
  output logic                      busy,
  output logic [GAIN_W-1:0]         gain,
  output logic [$clog2(NUM_CH)-1:0] sel_ch,
  output logic [NUM_CH-1:0]         mute
);

  localparam int unsigned SelW = $clog2(NUM_CH);

  sysmode_t          mode_q, mode_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [NUM_CH-1:0] mute_q, mute_d;
  logic              req;
  sysmode_t          target;
  logic              chan_en;

  assign req    = set_edit | set_play | set_raw;
  assign target = req_target(set_edit, set_play, set_raw);

`ifdef MODE_SEQ_FADE_EN
  seq_state_t state_q, state_d;
  sysmode_t   tgt_q, tgt_d;
  logic       ramp_up, ramp_down;

  gain_ramp #(
    .GAIN_W    (GAIN_W),
    .GAIN_STEP (GAIN_STEP)
  ) u_gain_ramp (
    .clk       (clk),
    .rst       (rst),
    .up        (ramp_up),
    .down      (ramp_down),
    .load_max  (1'b0),
    .load_zero (1'b0),
    .gain      (gain)
  );

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    mode_d    = mode_q;
    ramp_up   = 1'b0;
    ramp_down = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (req && target != mode_q) begin
          tgt_d     = target;
          state_d   = ST_FADE_OUT;
          ramp_down = 1'b1;
        end
      end
      ST_FADE_OUT: begin
        // Re-requesting the current mode backs out of the fade without swapping.
        if (req && target == mode_q) begin
          state_d = ST_FADE_IN;
          ramp_up = 1'b1;
        end else begin
          if (req) begin
            tgt_d = target;
          end
          if (gain == '0) begin
            state_d = ST_SWAP;
            mode_d  = req ? target : tgt_q;
          end else begin
            ramp_down = 1'b1;
          end
        end
      end
      ST_SWAP: begin
        state_d = ST_FADE_IN;
        ramp_up = 1'b1;
      end
      default: begin
        if (gain == '1) begin
          state_d = ST_STABLE;
        end else begin
          ramp_up = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STABLE;
      tgt_q   <= Edit;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  assign busy    = (state_q != ST_STABLE);
  assign chan_en = (state_q == ST_STABLE) && (mode_q == Edit);
`else
  always_comb begin
    mode_d = mode_q;
    if (req && target != mode_q) begin
      mode_d = target;
    end
  end

  assign busy    = 1'b0;
  assign gain    = '1;
  assign chan_en = (mode_q == Edit);
`endif

  // Toggle uses the pre-advance selection when both ops coincide.
  always_comb begin
    sel_d  = sel_q;
    mute_d = mute_q;
    if (chan_en) begin
      if (ch_mute_tgl) begin
        mute_d[sel_q] = ~mute_q[sel_q];
      end
      if (ch_next) begin
        sel_d = (sel_q == SelW'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= Edit;
      sel_q  <= '0;
      mute_q <= '0;
    end else begin
      mode_q <= mode_d;
      sel_q  <= sel_d;
      mute_q <= mute_d;
    end
  end

  assign mode   = mode_q;
  assign sel_ch = sel_q;
  assign mute   = mute_q;

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of mixer channels (2..16).
REQ-002 Parameter GAIN_W, default 8, SHALL set the master gain width; GAIN_MAX = 2^GAIN_W-1.
REQ-003 Parameter GAIN_STEP, default 16, SHALL set the gain change per fade cycle (1..GAIN_MAX).
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 set_edit, set_play, set_raw  in  1 each  mode request pulses.
REQ-007 ch_next  in  1  advance selected channel.
REQ-008 ch_mute_tgl  in  1  toggle mute of selected channel.
REQ-009 mode  out  2  current mode: EDIT=0, PLAY=1, RAW=2; 3 never driven.
REQ-010 busy  out  1  high while a mode transition is in progress.
REQ-011 gain  out  GAIN_W  master fade gain applied by the datapath.
REQ-012 sel_ch  out  $clog2(NUM_CH)  selected channel index.
REQ-013 mute  out  NUM_CH  per-channel mute, bit i = channel i.

Function
REQ-014 FSM states SHALL be STABLE, FADE_OUT, SWAP, FADE_IN; busy = (state != STABLE).
REQ-015 Request priority in one cycle SHALL be set_edit > set_play > set_raw; the winner is the request target.
REQ-016 In STABLE, a target equal to mode SHALL be ignored; a differing target SHALL be latched, state <= FADE_OUT, gain <= max(gain-GAIN_STEP, 0) on the same edge.
REQ-017 In FADE_OUT, gain SHALL decrement by GAIN_STEP per cycle, saturating at 0; when gain == 0, next edge: state <= SWAP, mode <= latched target.
REQ-018 In FADE_OUT, a new differing request SHALL replace the latched target; a request equal to current mode SHALL abort: next edge state <= FADE_IN, gain += GAIN_STEP.
REQ-019 In SWAP (exactly one cycle, gain 0), next edge: state <= FADE_IN, gain <= min(GAIN_STEP, GAIN_MAX).
REQ-020 In FADE_IN, gain SHALL increment by GAIN_STEP per cycle, saturating at GAIN_MAX; when gain == GAIN_MAX, next edge state <= STABLE.
REQ-021 Mode requests arriving in SWAP or FADE_IN SHALL be dropped.
REQ-022 ch_next and ch_mute_tgl SHALL be acted on only when state == STABLE and mode == EDIT; otherwise ignored.
REQ-023 ch_next SHALL increment sel_ch, wrapping NUM_CH-1 -> 0.
REQ-024 ch_mute_tgl SHALL invert mute[sel_ch]; when concurrent with ch_next, toggle applies to the pre-advance sel_ch.
REQ-025 Channel ops and a mode request in the same STABLE/EDIT cycle SHALL both take effect.

Reset
REQ-026 On rst: mode = EDIT, state = STABLE, busy = 0, gain = GAIN_MAX, sel_ch = 0, mute = 0, latched target = EDIT.
REQ-027 rst mid-transition SHALL abort it immediately to reset values; rst overrides all inputs.

Configuration
REQ-028 Macro MODE_SEQ_FADE_EN defined: full fade behaviour per REQ-014..021.
REQ-029 MODE_SEQ_FADE_EN undefined: differing request updates mode on the next edge, gain constant GAIN_MAX, busy constant 0, FSM removed; channel ops unchanged.

Structure
REQ-030 Shared package mixer_pkg SHALL hold sysmode_t (EDIT/PLAY/RAW), seq_state_t, and mode encoding constants.
REQ-031 One sub-module gain_ramp SHALL implement the saturating up/down gain register (inputs up, down, load_max, load_zero).

Verification (GAIN_W=8, GAIN_STEP=64, NUM_CH=4)
REQ-032 Reset, set_play pulse at edge 0 -> gain 191,127,63,0; SWAP with mode=1; gain 64,128,192,255; busy low from edge 9.
REQ-033 In PLAY, set_edit and set_raw same cycle -> target EDIT, mode ends 0.
REQ-034 From EDIT, set_play then set_edit during FADE_OUT at gain 127 -> gain 191,255, mode stays 0, no SWAP.
REQ-035 EDIT STABLE, four ch_next pulses -> sel_ch 1,2,3,0; ch_next+ch_mute_tgl at sel_ch 2 -> mute=4'b0100, sel_ch=3.
REQ-036 In PLAY, ch_mute_tgl and ch_next -> mute and sel_ch unchanged; set_raw during FADE_IN -> dropped.
REQ-037 rst asserted during FADE_OUT -> next cycle mode=0, gain=255, busy=0, mute=0.
